phy_rx_serie_paralelo: RTL and testbench
========================================

// Module: phy_rx_serie_paralelo
// PURPOSE
//  Receive-side serial-to-parallel stage. Sits directly downstream of the PHY TX
//  parallel-to-serial output and consumes its 1-bit stream, MSB first.
//  Finds byte alignment on the COM symbol and declares the link active after
//  ALIGN_COUNT consecutive aligned COMs. Then emits one byte per 8 bit-clocks,
//  with a valid strobe; COM (idle) bytes are filtered out.
// PARAMETERS
//  WIDTH        8      byte width; bit counter range 0..WIDTH-1
//  COM_BYTE     8'hBC  idle/alignment symbol sent by the TX when no lane is valid
//  ALIGN_COUNT  4      consecutive aligned COMs required to enter ACTIVE (>=1)
// PORTS
//  clk        in   1      bit clock; all state updates on its rising edge
//  reset      in   1      asynchronous, active-low; 0 forces reset state immediately
//  data_in    in   1      serial bit from TX, sampled every rising edge, MSB first
//  data_out   out  WIDTH  last received non-COM byte, held between strobes
//  valid_out  out  1      one-cycle strobe: data_out updated with a new data byte
//  active     out  1      1 while in ACTIVE (link aligned)
// BEHAVIOUR
//  - Reset (reset==0): state=SEARCH; shift_reg=0, bit_cnt=0, com_cnt=0;
//    data_out=0, valid_out=0, active=0. Release takes effect on the next rising edge.
//  - win = {shift_reg[WIDTH-2:0], data_in}: the byte that completes on this edge.
//    shift_reg <= win on every edge, in every state.
//  - SEARCH: bit-by-bit hunt. If win==COM_BYTE:
//    bit_cnt<=0 (next bit starts a byte) and com_cnt<=1.
//    If ALIGN_COUNT==1, go to ACTIVE; otherwise go to LOCK.
//    If win!=COM_BYTE, stay in SEARCH. bit_cnt is don't-care, held at 0.
//  - LOCK: bit_cnt increments each edge and wraps WIDTH-1 -> 0.
//    Byte boundary = edge where bit_cnt==WIDTH-1.
//    At a boundary, if win==COM_BYTE: com_cnt+1. When the new value equals
//    ALIGN_COUNT, go to ACTIVE and com_cnt<=0.
//    At a boundary, if win!=COM_BYTE: go to SEARCH, com_cnt<=0,
//    and do NOT re-hunt on this same edge.
//    No data output in LOCK.
//  - ACTIVE: bit_cnt keeps counting and wrapping. At each boundary:
//    win!=COM_BYTE -> data_out<=win, valid_out<=1 for exactly that one cycle.
//    win==COM_BYTE -> valid_out<=0; data_out holds.
//    At non-boundary edges, valid_out<=0.
//    ACTIVE is left only by reset; no loss-of-lock detection in this block.
//  - active is registered: it is 1 from the edge that enters ACTIVE.
//  - Latency: data_out/valid_out change on the same edge that samples the byte's
//    LSB. Back-to-back data bytes give valid_out pulses exactly WIDTH cycles apart.
//  - A COM inside the data stream while ACTIVE is treated as idle, never output.
//  - Reset mid-byte or mid-LOCK discards the partial byte and com_cnt.
//    Realignment restarts from SEARCH.
//  - All outputs are registered; there are no combinational paths from data_in
//    to outputs.
// TESTING
//  1. Hold reset=0 for 3 clks, feeding 1s -> data_out=0, valid_out=0, active=0.
//     Outputs reach 0 asynchronously, with no clock edge needed.
//  2. Send 4 back-to-back 8'hBC, then 8'hA5, 8'h3C:
//     - active rises on the edge of the 32nd bit;
//     - valid_out pulses on bits 40 and 48;
//     - data_out=8'hA5, then 8'h3C.
//  3. Send 3 junk bits, then 4x BC, then 8'h5A -> alignment is found at bit 11.
//     active rises on bit 35; data_out=8'h5A with valid_out on bit 43.
//  4. Send BC, BC, 8'h11, BC, BC, BC, BC, 8'h22:
//     - LOCK aborts at 8'h11 (active stays 0);
//     - the later 4x BC align;
//     - data_out=8'h22 pulses once; 8'h11 is never output.
//  5. While ACTIVE, send 8'h77, BC, BC, 8'h88:
//     - exactly two valid_out pulses, 24 clks apart;
//     - data_out holds 8'h77 through the BC bytes.
//  6. Assert reset mid-byte while ACTIVE -> active=0 immediately.
//     Re-sending 4x BC plus 8'hF0 yields data_out=8'hF0.

Source files
------------

// File: rtl/phy_rx_serie_paralelo.sv
// Receive-side serial-to-parallel stage: hunts for COM alignment, locks after a run
// of aligned COMs, then emits one data byte per WIDTH bit-clocks with COMs filtered.
module phy_rx_serie_paralelo #(
    parameter int          WIDTH       = 8,
    parameter logic [7:0]  COM_BYTE    = 8'hBC,
    parameter int          ALIGN_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int COM_W = $clog2(ALIGN_COUNT + 1);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [COM_W-1:0] COM_GOAL  = COM_W'(ALIGN_COUNT);
    localparam logic [COM_W-1:0] COM_ONE   = COM_W'(1);
    localparam logic [WIDTH-1:0] COM_WORD  = WIDTH'(COM_BYTE);

    typedef enum logic [1:0] {
        SEARCH,
        LOCK,
        ACTIVE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic [COM_W-1:0] com_cnt, com_cnt_next;
    logic [WIDTH-1:0] data_out_next;
    logic             valid_out_next;
    logic             active_next;

    logic [WIDTH-1:0] win;
    logic             win_is_com;
    logic             boundary;
    logic [CNT_W-1:0] bit_cnt_inc;
    logic [COM_W-1:0] com_cnt_inc;

    assign win         = {shift_reg[WIDTH-2:0], data_in};
    assign win_is_com  = (win == COM_WORD);
    assign boundary    = (bit_cnt == LAST_BIT);
    assign bit_cnt_inc = boundary ? '0 : bit_cnt + CNT_W'(1);
    assign com_cnt_inc = com_cnt + COM_ONE;

    // The shifter runs in every state so the hunt window is always the newest WIDTH bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            shift_reg <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= win;
            bit_cnt   <= bit_cnt_next;
            com_cnt   <= com_cnt_next;
            data_out  <= data_out_next;
            valid_out <= valid_out_next;
            active    <= active_next;
        end
    end

    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        com_cnt_next   = com_cnt;
        data_out_next  = data_out;
        valid_out_next = 1'b0;

        case (state)
            SEARCH: begin
                bit_cnt_next = '0;
                if (win_is_com) begin
                    com_cnt_next = COM_ONE;
                    state_next   = (ALIGN_COUNT == 1) ? ACTIVE : LOCK;
                end
            end

            // A non-COM at a boundary drops back to SEARCH without re-hunting this edge.
            LOCK: begin
                bit_cnt_next = bit_cnt_inc;
                if (boundary) begin
                    if (win_is_com) begin
                        if (com_cnt_inc == COM_GOAL) begin
                            state_next   = ACTIVE;
                            com_cnt_next = '0;
                        end else begin
                            com_cnt_next = com_cnt_inc;
                        end
                    end else begin
                        state_next   = SEARCH;
                        com_cnt_next = '0;
                        bit_cnt_next = '0;
                    end
                end
            end

            ACTIVE: begin
                bit_cnt_next = bit_cnt_inc;
                if (boundary && !win_is_com) begin
                    data_out_next  = win;
                    valid_out_next = 1'b1;
                end
            end

            default: begin
                state_next   = SEARCH;
                bit_cnt_next = '0;
                com_cnt_next = '0;
            end
        endcase

        active_next = (state_next == ACTIVE);
    end

endmodule

// File: tb/tb_phy_rx_serie_paralelo.sv
// Directed, table-driven bench for phy_rx_serie_paralelo: bytes are shifted in MSB
// first and the registered outputs are compared after each byte's last bit.
module tb_phy_rx_serie_paralelo;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int total_cnt = 0;
    int bad_cnt   = 0;

    phy_rx_serie_paralelo dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       do_reset;
        logic [7:0] din;
        int         nbits;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_active;
    } vec_t;

    vec_t vecs [0:28];

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sendBit(input logic b);
        @(negedge clk);
        data_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic applyStimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        if (v.do_reset) pulseReset();
        for (int i = v.nbits - 1; i >= 0; i--) begin
            sendBit(v.din[i]);
            if (i != 0) checkOutput($sformatf("valid_mid[%0d]", idx), {7'd0, valid_out}, 8'd0);
        end
        checkOutput($sformatf("valid[%0d]", idx),  {7'd0, valid_out}, {7'd0, v.exp_valid});
        checkOutput($sformatf("data[%0d]", idx),   data_out,           v.exp_data);
        checkOutput($sformatf("active[%0d]", idx), {7'd0, active},    {7'd0, v.exp_active});
    endtask

    task automatic setVec(input int idx, input logic rst, input logic [7:0] din, input int nbits,
                          input logic ev, input logic [7:0] ed, input logic ea);
        vecs[idx].do_reset   = rst;
        vecs[idx].din        = din;
        vecs[idx].nbits      = nbits;
        vecs[idx].exp_valid  = ev;
        vecs[idx].exp_data   = ed;
        vecs[idx].exp_active = ea;
    endtask

    initial begin
        // four COMs align (active on bit 32), then two data bytes
        setVec(0,  1, 8'hBC, 8, 0, 8'h00, 0);
        setVec(1,  0, 8'hBC, 8, 0, 8'h00, 0);
        setVec(2,  0, 8'hBC, 8, 0, 8'h00, 0);
        setVec(3,  0, 8'hBC, 8, 0, 8'h00, 1);
        setVec(4,  0, 8'hA5, 8, 1, 8'hA5, 1);
        setVec(5,  0, 8'h3C, 8, 1, 8'h3C, 1);
        // idle COMs inside the data stream hold data_out
        setVec(6,  0, 8'h77, 8, 1, 8'h77, 1);
        setVec(7,  0, 8'hBC, 8, 0, 8'h77, 1);
        setVec(8,  0, 8'hBC, 8, 0, 8'h77, 1);
        setVec(9,  0, 8'h88, 8, 1, 8'h88, 1);
        // three junk bits shift the alignment to bit 11
        setVec(10, 1, 8'h00, 3, 0, 8'h00, 0);
        setVec(11, 0, 8'hBC, 8, 0, 8'h00, 0);
        setVec(12, 0, 8'hBC, 8, 0, 8'h00, 0);
        setVec(13, 0, 8'hBC, 8, 0, 8'h00, 0);
        setVec(14, 0, 8'hBC, 8, 0, 8'h00, 1);
        setVec(15, 0, 8'h5A, 8, 1, 8'h5A, 1);
        // LOCK aborted by 0x11, then realigned
        setVec(16, 1, 8'hBC, 8, 0, 8'h00, 0);
        setVec(17, 0, 8'hBC, 8, 0, 8'h00, 0);
        setVec(18, 0, 8'h11, 8, 0, 8'h00, 0);
        setVec(19, 0, 8'hBC, 8, 0, 8'h00, 0);
        setVec(20, 0, 8'hBC, 8, 0, 8'h00, 0);
        setVec(21, 0, 8'hBC, 8, 0, 8'h00, 0);
        setVec(22, 0, 8'hBC, 8, 0, 8'h00, 1);
        setVec(23, 0, 8'h22, 8, 1, 8'h22, 1);
        // realignment after a mid-byte reset
        setVec(24, 0, 8'hBC, 8, 0, 8'h00, 0);
        setVec(25, 0, 8'hBC, 8, 0, 8'h00, 0);
        setVec(26, 0, 8'hBC, 8, 0, 8'h00, 0);
        setVec(27, 0, 8'hBC, 8, 0, 8'h00, 1);
        setVec(28, 0, 8'hF0, 8, 1, 8'hF0, 1);

        reset   = 1'b1;
        data_in = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        checkOutput("rst_async_data",   data_out,           8'h00);
        checkOutput("rst_async_valid",  {7'd0, valid_out}, 8'd0);
        checkOutput("rst_async_active", {7'd0, active},    8'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_hold_data",   data_out,           8'h00);
        checkOutput("rst_hold_valid",  {7'd0, valid_out}, 8'd0);
        checkOutput("rst_hold_active", {7'd0, active},    8'd0);

        for (int i = 0; i <= 23; i++) applyStimulus(i);

        // reset in the middle of a byte while ACTIVE, with no clock edge involved
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_active", {7'd0, active},    8'd0);
        checkOutput("midrst_valid",  {7'd0, valid_out}, 8'd0);
        checkOutput("midrst_data",   data_out,           8'h00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 24; i <= 28; i++) applyStimulus(i);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
